uart_menu_client: RTL and testbench

Host-side counterpart of the on-chip UART menu responder: accepts a single command character from local logic, transmits it through a `uart_tx`-style byte interface, then captures every byte the responder returns into a response FIFO until the line goes quiet. It sits between a `uart_tx`/`uart_rx` pair (same baud-tick generator) and a test or controller harness that drains the captured text. This allows a second tile, or the bench, to drive the menu protocol end to end.

---
 rtl/unisnano_pkg.sv | 35 +++
 rtl/uart_menu_client_resp_fifo.sv | 76 +++++++
 rtl/uart_menu_client.sv | 192 +++++++++++++++++++
 tb/tb_uart_menu_client.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unisnano_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : unisnano_pkg                                                 |
// | Description : Shared types and constants for the UART menu client and the  |
// |               on-chip menu responder it talks to.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package unisnano_pkg;

  // Client sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_TX = 2'd2,
    ST_COLLECT = 2'd3
  } client_state_e;

  // Range of command characters the responder understands ('1'..'5')
  localparam logic [7:0] CMD_FIRST = 8'h31;
  localparam logic [7:0] CMD_LAST  = 8'h35;

  // Menu sections selected by each command character (shared with responder)
  localparam logic [7:0] MENU_SEC_LED    = 8'h31;
  localparam logic [7:0] MENU_SEC_SWITCH = 8'h32;
  localparam logic [7:0] MENU_SEC_TIMER  = 8'h33;
  localparam logic [7:0] MENU_SEC_MEMORY = 8'h34;
  localparam logic [7:0] MENU_SEC_STATUS = 8'h35;

  // True when the character selects one of the menu sections
  function automatic logic is_menu_cmd(input logic [7:0] c);
    return (c >= CMD_FIRST) && (c <= CMD_LAST);
  endfunction

endpackage : unisnano_pkg
`default_nettype wire

// File: rtl/uart_menu_client_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : resp_fifo                                                    |
// | Description : Synchronous byte FIFO with clear, push, pop, occupancy count |
// |               and full/empty flags. Occupancy is held in a count register;|
// |               a push while full only lands if a pop frees a slot.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module resp_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int                c_AW        = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_pop_en;
  logic            w_push_en;

  assign full      = (r_count == c_DEPTH_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  // Clear wins over everything; a full FIFO accepts a push only alongside a pop
  assign w_pop_en  = pop & ~empty & ~clear;
  assign w_push_en = push & ~clear & (~full | w_pop_en);

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : resp_fifo
`default_nettype wire

// File: rtl/uart_menu_client.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_menu_client                                             |
// | Description : Sends one command character through a uart_tx-style byte    |
// |               interface, then captures the responder's reply bytes into a |
// |               FIFO until the line stays quiet for QUIET_CYCLES.            |
// |               Optional macro UART_MENU_CLIENT_CMD_FILTER_EN restricts      |
// |               commands to '1'..'5'; others are consumed with a timeout.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_menu_client
  import unisnano_pkg::*;
#(
  parameter int QUIET_CYCLES = 100000,
  parameter int TX_TIMEOUT   = 100000000,
  parameter int RESP_DEPTH   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  input  logic [7:0]                    cmd_data,
  output logic                          cmd_ready,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          tx_done_tick,
  input  logic                          rx_done_tick,
  input  logic [7:0]                    rx_data,
  output logic                          rsp_valid,
  output logic [7:0]                    rsp_data,
  input  logic                          rsp_ready,
  output logic [$clog2(RESP_DEPTH):0]   rsp_count,
  output logic                          done,
  output logic                          timeout,
  output logic                          overflow,
  output logic                          busy
);

  localparam int c_CYC_W   = $clog2(TX_TIMEOUT + 1);
  localparam int c_QUIET_W = $clog2(QUIET_CYCLES + 1);
  localparam int c_CAP_W   = 16;

  localparam logic [c_CYC_W-1:0]   c_TX_LIMIT    = c_CYC_W'(TX_TIMEOUT);
  localparam logic [c_QUIET_W-1:0] c_QUIET_LIMIT = c_QUIET_W'(QUIET_CYCLES);

  client_state_e        r_state;
  client_state_e        w_state_next;
  logic [7:0]           r_tx_data;
  logic                 r_overflow;
  logic [c_CYC_W-1:0]   r_cyc_cnt;
  logic [c_QUIET_W-1:0] r_quiet_cnt;
  logic [c_CAP_W-1:0]   r_cap_cnt;

  logic                 w_cmd_ok;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [c_CYC_W-1:0]   w_cyc_inc;
  logic [c_QUIET_W-1:0] w_quiet_inc;
  logic                 w_tx_expire;
  logic                 w_quiet_expire;
  logic                 w_has_bytes;

`ifdef UART_MENU_CLIENT_CMD_FILTER_EN
  assign w_cmd_ok = is_menu_cmd(cmd_data);
`else
  assign w_cmd_ok = 1'b1;
`endif

  // A rejected command is still consumed in IDLE but never starts a transfer
  assign w_accept = (r_state == ST_IDLE) & cmd_valid & w_cmd_ok;

  // Capture window spans SEND through COLLECT; IDLE ignores the receiver
  assign w_push = (r_state != ST_IDLE) & rx_done_tick;
  // A simultaneous pop frees the slot, so only a pop-less push at full is lost
  assign w_drop = w_push & w_fifo_full & ~rsp_ready;

  // Saturating increments so long waits never wrap back to a small value
  assign w_cyc_inc   = (r_cyc_cnt == '1)   ? r_cyc_cnt   : r_cyc_cnt + c_CYC_W'(1);
  assign w_quiet_inc = (r_quiet_cnt == '1) ? r_quiet_cnt : r_quiet_cnt + c_QUIET_W'(1);

  assign w_tx_expire    = ~tx_done_tick & (w_cyc_inc >= c_TX_LIMIT);
  assign w_quiet_expire = ~rx_done_tick & (w_quiet_inc >= c_QUIET_LIMIT);
  assign w_has_bytes    = (r_cap_cnt != '0);

  assign tx_data   = r_tx_data;
  assign overflow  = r_overflow;
  assign rsp_valid = ~w_fifo_empty;

  resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_accept),
    .push      (w_push),
    .push_data (rx_data),
    .pop       (rsp_ready),
    .head_data (rsp_data),
    .count     (rsp_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_next = ST_SEND;
      ST_SEND:    w_state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_done_tick) begin
          w_state_next = ST_COLLECT;
        end else if (w_tx_expire) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_COLLECT: if (w_quiet_expire) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Handshake and pulse outputs; done/timeout fire in the last non-IDLE cycle
  always_comb begin
    cmd_ready = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    tx_start  = (r_state == ST_SEND);
    done      = 1'b0;
    timeout   = 1'b0;
    case (r_state)
      ST_IDLE:    timeout = cmd_valid & ~w_cmd_ok;
      ST_WAIT_TX: timeout = w_tx_expire;
      ST_COLLECT: begin
        done    = w_quiet_expire & w_has_bytes;
        timeout = w_quiet_expire & ~w_has_bytes;
      end
      default: ;
    endcase
  end

  // Command latch, sticky overflow and captured-byte count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
      r_cap_cnt  <= '0;
    end else if (w_accept) begin
      r_tx_data  <= cmd_data;
      r_overflow <= 1'b0;
      r_cap_cnt  <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push && (r_cap_cnt != '1)) begin
        r_cap_cnt <= r_cap_cnt + c_CAP_W'(1);
      end
    end
  end

  // Transmit-wait and line-quiet counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt   <= '0;
      r_quiet_cnt <= '0;
    end else begin
      case (r_state)
        ST_SEND:    r_cyc_cnt <= '0;
        ST_WAIT_TX: begin
          r_cyc_cnt <= w_cyc_inc;
          if (tx_done_tick) begin
            r_quiet_cnt <= '0;
          end
        end
        ST_COLLECT: r_quiet_cnt <= rx_done_tick ? '0 : w_quiet_inc;
        default: ;
      endcase
    end
  end

endmodule : uart_menu_client
`default_nettype wire

// File: tb/tb_uart_menu_client.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_menu_client                                          |
// | Description : Scoreboard bench for uart_menu_client. A driver schedules   |
// |               commands and reply bytes on absolute cycles; a monitor      |
// |               compares pulses, FIFO bytes and status against a queue model|
// |               Honours UART_MENU_CLIENT_CMD_FILTER_EN when defined.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_menu_client;

  localparam int QUIET = 40;
  localparam int TXTO  = 60;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int EV_TX   = 0;
  localparam int EV_DONE = 1;
  localparam int EV_TO   = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } evt_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_data = 8'h00;
  logic          tx_done_tick = 1'b0;
  logic          rx_done_tick = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rsp_ready = 1'b0;
  logic          cmd_ready, tx_start, rsp_valid, done, timeout, overflow, busy;
  logic [7:0]    tx_data, rsp_data;
  logic [CW-1:0] rsp_count;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         drain_pct = 0;
  evt_t       evq[$];
  logic [7:0] mq[$];
  logic [7:0] stim_q[$];
  bit         exp_ovf = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_accept = 1'b0;

  uart_menu_client #(
    .QUIET_CYCLES (QUIET),
    .TX_TIMEOUT   (TXTO),
    .RESP_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .rsp_count    (rsp_count),
    .done         (done),
    .timeout      (timeout),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic see_evt(input int kind, input logic [7:0] data);
    evt_t e;
    checks++;
    if (evq.size() == 0) begin
      failures++;
      $display("FAIL pulse: unexpected kind %0d at cycle %0d, expected no pulse", kind, cyc);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == EV_TX && e.data !== data)) begin
        failures++;
        $display("FAIL pulse: got kind %0d cycle %0d data %0h expected kind %0d cycle %0d data %0h",
                 kind, cyc, data, e.kind, e.cyc, e.data);
      end
    end
  endtask

  function automatic bit cmd_ok(input logic [7:0] c);
`ifdef UART_MENU_CLIENT_CMD_FILTER_EN
    return (c >= 8'h31) && (c <= 8'h35);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void push_evt(input int c, input int kind, input logic [7:0] data);
    evt_t e;
    e.cyc  = c;
    e.kind = kind;
    e.data = data;
    evq.push_back(e);
  endfunction

  // Monitor: scoreboard comparison of every visible output each cycle
  initial begin : monitor
    bit pop;
    bit full_before;
    forever begin
      @(negedge clk);
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_pulse: kind %0d got none by cycle %0d expected at cycle %0d",
                 evq[0].kind, cyc, evq[0].cyc);
        evq.delete(0);
      end
      if (tx_start) see_evt(EV_TX, tx_data);
      if (done)     see_evt(EV_DONE, 8'h00);
      if (timeout)  see_evt(EV_TO, 8'h00);
      chk("busy", busy, m_busy);
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("rsp_valid", rsp_valid, mq.size() != 0);
      chk("rsp_count", rsp_count, mq.size());
      chk("overflow", overflow, exp_ovf);
      if (rst_n) begin
        pop = rsp_ready && (mq.size() > 0);
        if (pop) chk("rsp_data", rsp_data, mq[0]);
        if (m_accept) begin
          mq.delete();
          exp_ovf = 1'b0;
        end else begin
          full_before = (mq.size() == DEPTH);
          if (pop) mq.delete(0);
          if (rx_done_tick && m_busy) begin
            if (!full_before || pop) mq.push_back(rx_data);
            else exp_ovf = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    rsp_ready    = ($urandom_range(0, 99) < drain_pct);
  endtask

  // One command round trip; reply bytes come from stim_q
  task automatic run_txn(input logic [7:0] cmd, input bit withhold, input bit wait_byte,
                         input int drain, input int max_gap, input bit rst_mid);
    int n, tdone, last, endc, total, gap, idle;
    logic [7:0] b;
    drain_pct = drain;
    idle = $urandom_range(1, 3);
    for (int i = 0; i < idle; i++) begin
      step();
      rx_done_tick = ($urandom_range(0, 3) == 0);
      rx_data      = 8'($urandom);
    end
    step();
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    n = cyc;
    if (!cmd_ok(cmd)) begin
      push_evt(n, EV_TO, 8'h00);
      stim_q.delete();
      step();
      cmd_valid = 1'b0;
      return;
    end
    m_accept = 1'b1;
    push_evt(n + 1, EV_TX, cmd);
    step();
    cmd_valid = 1'b0;
    m_accept  = 1'b0;
    m_busy    = 1'b1;
    if (withhold) begin
      stim_q.delete();
      endc = n + 1 + TXTO;
      push_evt(endc, EV_TO, 8'h00);
      while (cyc < endc) step();
      step();
      m_busy = 1'b0;
      return;
    end
    tdone = n + 1 + $urandom_range(2, 15);
    total = 0;
    while (cyc < tdone) begin
      step();
      if (wait_byte && cyc == n + 2) begin
        rx_done_tick = 1'b1;
        rx_data      = 8'($urandom);
        total++;
      end
    end
    tx_done_tick = 1'b1;
    last = tdone;
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      gap = $urandom_range(1, max_gap);
      repeat (gap) step();
      rx_done_tick = 1'b1;
      rx_data      = b;
      total++;
      last = cyc;
    end
    if (rst_mid) begin
      step();
      rx_done_tick = 1'b1;
      rx_data      = 8'hA5;
      rsp_ready    = 1'b1;
      step();
      chk("pushpop_full_count", rsp_count, DEPTH);
      rst_n = 1'b0;
      mq.delete();
      evq.delete();
      exp_ovf  = 1'b0;
      m_busy   = 1'b0;
      m_accept = 1'b0;
      repeat (2) step();
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_count", rsp_count, 0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      rst_n = 1'b1;
      return;
    end
    endc = last + QUIET;
    push_evt(endc, (total > 0) ? EV_DONE : EV_TO, 8'h00);
    while (cyc < endc) step();
    step();
    m_busy = 1'b0;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected TB_RESULT");
    $fatal(1);
  end

  initial begin : driver
    string s;
    logic [7:0] c;
    int nb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_start", tx_start, 1'b0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_timeout", timeout, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_count", rsp_count, 0);
    rst_n = 1'b1;

    // '1' with an eight-byte reply, drained afterwards in order
    s = "LED menu";
    foreach (s[i]) stim_q.push_back(s[i]);
    run_txn(8'h31, 1'b0, 1'b0, 0, QUIET / 2, 1'b0);
    chk("t1_count", rsp_count, 8);
    drain_pct = 100;
    repeat (12) step();
    chk("t1_drained", rsp_count, 0);

    // '2' with tx_done withheld
    run_txn(8'h32, 1'b1, 1'b0, 0, 1, 1'b0);
    chk("t2_count", rsp_count, 0);
    chk("t2_cmd_ready", cmd_ready, 1'b1);

    // '4' with a silent responder
    run_txn(8'h34, 1'b0, 1'b0, 0, 1, 1'b0);

    // 70 bytes into a 64-deep FIFO with no draining
    for (int i = 0; i < 70; i++) stim_q.push_back(8'($urandom));
    run_txn(8'h33, 1'b0, 1'b0, 0, 2, 1'b0);
    chk("ovf_count", rsp_count, DEPTH);
    chk("ovf_flag", overflow, 1'b1);
    drain_pct = 100;
    repeat (70) step();
    chk("ovf_drained", rsp_count, 0);
    chk("ovf_sticky", overflow, 1'b1);

    // Next command clears the sticky overflow
    for (int i = 0; i < 3; i++) stim_q.push_back(8'($urandom));
    run_txn(8'h35, 1'b0, 1'b1, 0, 5, 1'b0);
    chk("ovf_cleared", overflow, 1'b0);

    // Fill, push+pop at full, then reset mid-collect
    for (int i = 0; i < 66; i++) stim_q.push_back(8'($urandom));
    run_txn(8'h31, 1'b0, 1'b0, 0, 1, 1'b1);
    repeat (3) step();

    // Out-of-range command, then a valid one
    stim_q.push_back(8'h4F);
    stim_q.push_back(8'h4B);
    run_txn(8'h39, 1'b0, 1'b0, 50, 10, 1'b0);
    stim_q.push_back(8'h53);
    run_txn(8'h35, 1'b0, 1'b0, 50, 10, 1'b0);

    // Randomized round trips
    for (int t = 0; t < 16; t++) begin
      c  = ($urandom_range(0, 1) == 1) ? 8'(8'h31 + $urandom_range(0, 4)) : 8'($urandom);
      nb = $urandom_range(0, 12);
      for (int i = 0; i < nb; i++) stim_q.push_back(8'($urandom));
      run_txn(c, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 100), QUIET / 2, 1'b0);
    end

    drain_pct = 100;
    repeat (30) step();
    chk("pending_events", evq.size(), 0);
    chk("final_count", rsp_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_menu_client
`default_nettype wire
